hack_mem_ctrl: RTL and testbench
================================

# hack_mem_ctrl

Data-memory responder for the Hack CPU. It serves the CPU's `addressM`/`outM`/`writeM` requests and returns `inM` with a fixed one-cycle read latency, which matches the CPU's single MEM_READ stall cycle. It decodes the Hack memory map into three regions: general RAM, a dual-port screen buffer with a second read port for the video controller, and a keyboard register fed by the PS/2 decoder. It sits between the CPU data port and the RAM, video and keyboard blocks.

## Interface
- `WIDTH`, 16: data and address width.
- `RAM_AW`, 14: RAM word-address width (16384 words at 0x0000–0x3FFF).
- `SCREEN_AW`, 13: screen word-address width (8192 words at 0x4000–0x5FFF).
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `addressM`  in  WIDTH  CPU data address.
- `outM`  in  WIDTH  CPU write data.
- `writeM`  in  1  CPU write enable; the write commits at the rising edge.
- `inM`  out  WIDTH  read data for the address sampled at the previous edge.
- `kbd_valid`  in  1  one-cycle pulse: `kbd_data` holds a new key state.
- `kbd_data`  in  WIDTH  key code; 0 means no key pressed.
- `vid_rd`  in  1  video read request.
- `vid_addr`  in  SCREEN_AW  video word address.
- `vid_data`  out  WIDTH  screen word for the last accepted `vid_rd`.
- `vid_valid`  out  1  `vid_data` is valid this cycle.
- `bus_err`  out  1  sticky flag: an access hit an unmapped address.

## Operation
- Address decode on `addressM`:
  - RAM when `addressM[15:14]==2'b00`.
  - SCREEN when `addressM[15:13]==3'b010`.
  - KBD when `addressM==16'h6000`.
  - Everything else is UNMAPPED.
- Region select is registered at each edge alongside the memory read. `inM` is muxed from the registered select, so `inM` always belongs to the address presented one cycle earlier.
- Writes (`writeM=1`):
  - RAM and SCREEN: the word is written at the edge.
  - KBD: the write is ignored. It is legal and does not set `bus_err`.
  - UNMAPPED: the write is dropped and `bus_err` is set.
- Reads are issued every cycle regardless of `writeM`. There is no read-enable input.
- An UNMAPPED read returns 0 on `inM` the next cycle and sets `bus_err`. Reads of KBD are never errors.
- Both RAM and SCREEN (CPU port) are read-first on the same address. If a cycle reads and writes the same word, `inM` on the next cycle returns the old data. This makes the CPU's `M=M+1` sequence correct.
- Keyboard register:
  - Loads `kbd_data` on a `kbd_valid` pulse and otherwise holds.
  - A KBD read returns the register value as of the read edge. If `kbd_valid` and a KBD read coincide, `inM` shows the old value; the new value appears from the next read on.
- Screen video port:
  - Independent read port. `vid_rd` at edge N gives `vid_data` and `vid_valid=1` for cycle N+1.
  - If `vid_rd` is low, `vid_valid` is 0 and `vid_data` holds its last value.
  - A video read and a CPU write to the same screen word in the same cycle: the video read returns the old data (read-first).
  - The video port never stalls and never blocks the CPU.
- `bus_err` clears only on reset.
- Memory contents are not reset. Only registers reset.

## Timing
- Reset values: `inM`=0, `vid_data`=0, `vid_valid`=0, `bus_err`=0, keyboard register=0, registered select=RAM.
- Read latency: exactly 1 cycle for the CPU port and the video port. No wait states and no handshake on the CPU side.
- Write latency: a write is visible to a read issued at the next edge.
- `bus_err` rises on the edge after the offending access is sampled.
- If reset asserts mid-operation, all registers clear asynchronously. A write sampled on the same edge as reset assertion is not guaranteed. After reset deasserts, the first `inM` is 0 until the first post-reset edge.
- Address wrap-around: none. Decode is exact, so 0x3FFF→RAM, 0x4000→SCREEN, 0x5FFF→SCREEN, 0x6000→KBD, 0x6001→UNMAPPED, 0xFFFF→UNMAPPED.

## Test plan
- Write 0x1234 to RAM 0x0010, then read 0x0010 → `inM`=0x1234 one cycle after the read address. Read 0x3FFF after writing 0xBEEF → `inM`=0xBEEF.
- Same-cycle read+write to RAM 0x0020 (old value 5, write 6) → `inM`=5 next cycle. Re-read → `inM`=6.
- Pulse `kbd_valid` with `kbd_data`=0x0041, then read 0x6000 → `inM`=0x0041. Write 0xFFFF to 0x6000 → later read still 0x0041 and `bus_err`=0. Pulse `kbd_valid` with `kbd_data`=0 → read gives 0.
- CPU writes 0xAAAA to 0x4005 while `vid_rd`=1 with `vid_addr`=5 → `vid_data`=old value and `vid_valid`=1 next cycle. Next `vid_rd` → 0xAAAA.
- Read 0x6001 → `inM`=0 and `bus_err`=1 one cycle later. Write to 0x8000 → RAM 0x0000 unchanged. `bus_err` stays 1 until reset.
- Assert reset mid-sequence → `inM`, `vid_data`, `vid_valid`, `bus_err` and the keyboard register all return 0 immediately. Previously written RAM data is still readable after release.

Source files
------------

// File: rtl/hack_mem_ctrl.sv
// Hack CPU data-memory responder: RAM, dual-port screen buffer and keyboard register
// behind a one-cycle-latency read path, with a second screen read port for video.
module hack_mem_ctrl #(
  parameter int WIDTH     = 16,
  parameter int RAM_AW    = 14,
  parameter int SCREEN_AW = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     addressM,
  input  logic [WIDTH-1:0]     outM,
  input  logic                 writeM,
  output logic [WIDTH-1:0]     inM,
  input  logic                 kbd_valid,
  input  logic [WIDTH-1:0]     kbd_data,
  input  logic                 vid_rd,
  input  logic [SCREEN_AW-1:0] vid_addr,
  output logic [WIDTH-1:0]     vid_data,
  output logic                 vid_valid,
  output logic                 bus_err
);

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_SCR  = 2'd1,
    SEL_KBD  = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

  localparam logic [WIDTH-1:0] KBD_ADDR = WIDTH'(16'h6000);

  logic [WIDTH-1:0] ram    [2**RAM_AW];
  logic [WIDTH-1:0] screen [2**SCREEN_AW];

  sel_t             sel_p0;
  logic             we_ram_p0;
  logic             we_scr_p0;

  sel_t             sel_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] ram_rd_p1;
  logic [WIDTH-1:0] scr_rd_p1;
  logic [WIDTH-1:0] kbd_rd_p1;
  logic [WIDTH-1:0] kbd_reg;
  logic [WIDTH-1:0] vid_word_p1;
  logic             vid_seen_p1;

  // Stage p0: exact address decode of the CPU request
  always_comb begin
    sel_p0 = SEL_NONE;
    if (addressM[WIDTH-1 -: 2] == 2'b00)
      sel_p0 = SEL_RAM;
    else if (addressM[WIDTH-1 -: 3] == 3'b010)
      sel_p0 = SEL_SCR;
    else if (addressM == KBD_ADDR)
      sel_p0 = SEL_KBD;
  end

  assign we_ram_p0 = writeM && (sel_p0 == SEL_RAM);
  assign we_scr_p0 = writeM && (sel_p0 == SEL_SCR);

  // Stage p1: read-first memory ports; arrays and read data are not reset
  always_ff @(posedge clk) begin
    if (we_ram_p0)
      ram[addressM[RAM_AW-1:0]] <= outM;
    ram_rd_p1 <= ram[addressM[RAM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (we_scr_p0)
      screen[addressM[SCREEN_AW-1:0]] <= outM;
    scr_rd_p1 <= screen[addressM[SCREEN_AW-1:0]];
    if (vid_rd)
      vid_word_p1 <= screen[vid_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_p1      <= SEL_RAM;
      vld_p1      <= 1'b0;
      kbd_reg     <= '0;
      kbd_rd_p1   <= '0;
      vid_valid   <= 1'b0;
      vid_seen_p1 <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      sel_p1    <= sel_p0;
      vld_p1    <= 1'b1;
      kbd_rd_p1 <= kbd_reg;
      if (kbd_valid)
        kbd_reg <= kbd_data;
      vid_valid <= vid_rd;
      if (vid_rd)
        vid_seen_p1 <= 1'b1;
      if (sel_p0 == SEL_NONE)
        bus_err <= 1'b1;
    end
  end

  // Unreset memory data is masked to zero until a post-reset read has landed
  always_comb begin
    inM = '0;
    if (vld_p1) begin
      case (sel_p1)
        SEL_RAM: inM = ram_rd_p1;
        SEL_SCR: inM = scr_rd_p1;
        SEL_KBD: inM = kbd_rd_p1;
        default: inM = '0;
      endcase
    end
  end

  assign vid_data = vid_seen_p1 ? vid_word_p1 : '0;

endmodule

// File: tb/tb_hack_mem_ctrl.sv
// Directed bench for hack_mem_ctrl: hand-computed expectations for the RAM, screen,
// keyboard, unmapped and reset behaviour.
module tb_hack_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_data;
  logic        vid_rd;
  logic [12:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  hack_mem_ctrl #(.WIDTH(16), .RAM_AW(14), .SCREEN_AW(13)) dut (
    .clk       (clk),
    .reset     (reset),
    .addressM  (addressM),
    .outM      (outM),
    .writeM    (writeM),
    .inM       (inM),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .vid_rd    (vid_rd),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic [15:0] a, input logic w, input logic [15:0] d);
    addressM = a;
    writeM   = w;
    outM     = d;
    step();
  endtask

  initial begin
    reset = 1'b1; addressM = 16'h0000; outM = 16'h0000; writeM = 1'b0;
    kbd_valid = 1'b0; kbd_data = 16'h0000; vid_rd = 1'b0; vid_addr = '0;
    #3;
    chk("rst_inM", inM, 16'h0000);
    chk("rst_vid_data", vid_data, 16'h0000);
    chk("rst_vid_valid", {15'b0, vid_valid}, 16'h0000);
    chk("rst_bus_err", {15'b0, bus_err}, 16'h0000);
    step();
    step();
    reset = 1'b0;
    chk("rel_inM", inM, 16'h0000);

    // RAM write then read, including the top RAM word
    cpu(16'h0010, 1'b1, 16'h1234);
    cpu(16'h0010, 1'b0, 16'h0000);
    chk("ram_0010", inM, 16'h1234);
    cpu(16'h3FFF, 1'b1, 16'hBEEF);
    cpu(16'h3FFF, 1'b0, 16'h0000);
    chk("ram_3fff", inM, 16'hBEEF);
    cpu(16'h0000, 1'b1, 16'h7777);

    // Read-first on same-cycle read+write
    cpu(16'h0020, 1'b1, 16'h0005);
    cpu(16'h0020, 1'b1, 16'h0006);
    chk("ram_rf_old", inM, 16'h0005);
    cpu(16'h0020, 1'b0, 16'h0000);
    chk("ram_rf_new", inM, 16'h0006);

    // Keyboard register
    kbd_valid = 1'b1; kbd_data = 16'h0041;
    cpu(16'h0010, 1'b0, 16'h0000);
    kbd_valid = 1'b0; kbd_data = 16'h1111;
    cpu(16'h6000, 1'b0, 16'h0000);
    chk("kbd_41", inM, 16'h0041);
    cpu(16'h6000, 1'b1, 16'hFFFF);
    cpu(16'h6000, 1'b0, 16'h0000);
    chk("kbd_wr_ignored", inM, 16'h0041);
    chk("kbd_wr_no_err", {15'b0, bus_err}, 16'h0000);
    kbd_valid = 1'b1; kbd_data = 16'h0000;
    cpu(16'h6000, 1'b0, 16'h0000);
    chk("kbd_coincide_old", inM, 16'h0041);
    kbd_valid = 1'b0;
    cpu(16'h6000, 1'b0, 16'h0000);
    chk("kbd_zero", inM, 16'h0000);

    // Screen: CPU write colliding with a video read of the same word
    cpu(16'h4005, 1'b1, 16'h1111);
    vid_rd = 1'b1; vid_addr = 13'd5;
    cpu(16'h4005, 1'b1, 16'hAAAA);
    chk("vid_old", vid_data, 16'h1111);
    chk("vid_valid_1", {15'b0, vid_valid}, 16'h0001);
    chk("scr_cpu_old", inM, 16'h1111);
    vid_rd = 1'b0;
    cpu(16'h4005, 1'b0, 16'h0000);
    chk("vid_valid_0", {15'b0, vid_valid}, 16'h0000);
    chk("vid_hold", vid_data, 16'h1111);
    chk("scr_cpu_new", inM, 16'hAAAA);
    vid_rd = 1'b1;
    cpu(16'h4005, 1'b0, 16'h0000);
    chk("vid_new", vid_data, 16'hAAAA);
    vid_rd = 1'b0;
    cpu(16'h5FFF, 1'b1, 16'h5A5A);
    vid_rd = 1'b1; vid_addr = 13'h1FFF;
    cpu(16'h0000, 1'b0, 16'h0000);
    chk("ram_0000_vs_scr", inM, 16'h7777);
    vid_rd = 1'b0;
    chk("vid_5fff", vid_data, 16'h5A5A);
    chk("no_err_yet", {15'b0, bus_err}, 16'h0000);

    // Unmapped accesses
    cpu(16'h6001, 1'b0, 16'h0000);
    chk("unmap_6001_inM", inM, 16'h0000);
    chk("unmap_err", {15'b0, bus_err}, 16'h0001);
    cpu(16'h8000, 1'b1, 16'h9999);
    cpu(16'h0000, 1'b0, 16'h0000);
    chk("unmap_wr_dropped", inM, 16'h7777);
    cpu(16'hFFFF, 1'b0, 16'h0000);
    chk("unmap_ffff_inM", inM, 16'h0000);
    cpu(16'h0010, 1'b0, 16'h0000);
    chk("err_sticky", {15'b0, bus_err}, 16'h0001);

    // Asynchronous reset mid-operation
    kbd_valid = 1'b1; kbd_data = 16'h0055;
    vid_rd = 1'b1; vid_addr = 13'd5;
    cpu(16'h0010, 1'b0, 16'h0000);
    kbd_valid = 1'b0; vid_rd = 1'b0;
    chk("pre_rst_inM", inM, 16'h1234);
    chk("pre_rst_vid_valid", {15'b0, vid_valid}, 16'h0001);
    reset = 1'b1;
    #1;
    chk("mid_rst_inM", inM, 16'h0000);
    chk("mid_rst_vid_data", vid_data, 16'h0000);
    chk("mid_rst_vid_valid", {15'b0, vid_valid}, 16'h0000);
    chk("mid_rst_bus_err", {15'b0, bus_err}, 16'h0000);
    step();
    reset = 1'b0;
    addressM = 16'h6000;
    #1;
    chk("post_rel_inM", inM, 16'h0000);
    step();
    chk("post_rst_kbd", inM, 16'h0000);
    cpu(16'h0010, 1'b0, 16'h0000);
    chk("ram_survives_rst", inM, 16'h1234);
    chk("post_rst_no_err", {15'b0, bus_err}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
